// File: rtl/serial_adder_if.sv
// serial_adder_if: handshake/operand bundle for the bit-serial adder.
//   master : drives start, a, b, cin; observes busy, done, sum, cout (+ovf)
//   slave  : the adder side
// Optional macro SERIAL_ADDER_OVF_EN adds the 1-bit signed-overflow flag ovf.
interface serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell plus a carry
// flip-flop, LSB first, one bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_if.slave (start, a, b, cin in; busy, done, sum, cout out)
// A start accepted at edge k yields sum/cout and a one-cycle done pulse at edge
// k+WIDTH; the next start can be taken at edge k+WIDTH+2.
// Optional macro SERIAL_ADDER_OVF_EN adds bus.ovf, the two's-complement
// overflow of the addition, loaded and held alongside sum.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q, cout_q;
    logic [WIDTH-1:0] sum_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    // full-adder cell
    logic s, cn;
    assign s  = a_sr[0] ^ b_sr[0] ^ c;
    assign cn = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

    logic last;
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        c     <= bus.cin;
                        r_sr  <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    busy_q <= 1'b1;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    r_sr   <= {s, r_sr[WIDTH-1:1]};
                    c      <= cn;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        // result register would only hold this bit after the
                        // edge, so load the outputs from the live full-adder
                        sum_q  <= {s, r_sr[WIDTH-1:1]};
                        cout_q <= cn;
                        done_q <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        // c is the carry into the MSB on the final bit
                        ovf_q  <= c ^ cn;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder; the addition counterpart to the existing subtractor blocks.
- Latches two operands and a carry-in on a start pulse, then adds them LSB-first with one full-adder cell and a carry flip-flop, one bit per clock.
- Presents sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, and as the golden partner for subtractor verification (a - b recovered via a + ~b + 1).

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- cin  input  1  carry-in; latched on an accepted start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.

Behaviour:
- Reset values (asynchronous, while rst high):
  - State = IDLE.
  - busy = 0, done = 0, sum = 0, cout = 0.
  - Internal shift registers, carry flip-flop and bit counter = 0.
- States:
  - IDLE: start = 1 latches a, b and cin into internal registers, clears the bit counter, goes to SHIFT. start = 0 stays in IDLE.
  - SHIFT: each clock computes s = a_sr[0] ^ b_sr[0] ^ c and c' = majority(a_sr[0], b_sr[0], c).
    - s shifts into the MSB of the result shift register; a_sr and b_sr shift right.
    - The carry flip-flop takes c'; the counter increments.
    - After the WIDTH-th bit (counter = WIDTH-1 at the edge), goes to DONE.
  - DONE: sum and cout are loaded from the result register and carry flip-flop on entry. done = 1 for exactly this one cycle, then IDLE.
- Latency: start accepted at edge k. sum, cout and done update at edge k+WIDTH. done is high from edge k+WIDTH to k+WIDTH+1. The next start can be accepted at edge k+WIDTH+2.
- busy is registered: high from edge k+1 through the DONE cycle, low again in IDLE.
- start while busy is ignored; it is neither queued nor disturbs the operation. start held high continuously gives back-to-back operations with one IDLE cycle between them.
- Input stability: a, b and cin are don't-care except at the accepting edge. Changes during SHIFT have no effect.
- Output holding: sum and cout hold their last result until the next DONE entry. They do not change during SHIFT.
- Width rule: the full result is {cout, sum} = a + b + cin. Maximum is 2^(WIDTH+1) - 1. No saturation.
- Reset mid-operation:
  - The operation is aborted and state returns to IDLE immediately.
  - All outputs clear; no done pulse is produced.
  - The first start after rst falls behaves as from power-up.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit) = two's-complement signed overflow.
  - ovf = carry into the MSB XOR carry out of the MSB, captured during the final SHIFT cycle.
  - ovf is loaded alongside sum and cout in DONE, resets to 0, and holds like sum.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH = 4. After reset: sum = 0000, cout = 0, busy = 0, done = 0. Then a = 0011, b = 0101, cin = 0, start one cycle -> done pulse exactly 4 edges after the start edge, sum = 1000, cout = 0.
- Wrap with carry: a = 1111, b = 0001, cin = 0 -> sum = 0000, cout = 1. A second run a = 1111, b = 1111, cin = 1 -> sum = 1111, cout = 1.
- Carry-in path: a = 0000, b = 0000, cin = 1 -> sum = 0001, cout = 0. Subtract check: a = 0110, b = ~0010, cin = 1 -> sum = 0100, cout = 1.
- Busy rejection: start accepted with a = 0010, b = 0011; pulse start again 2 cycles later with a = 1111 -> result sum = 0101, single done pulse. start held high -> done pulses every 6 cycles.
- Reset mid-operation: assert rst 2 cycles into SHIFT, asynchronous to the clock -> busy, sum and cout drop to 0 immediately, no done pulse. The next op a = 0001, b = 0001 -> sum = 0010.
- With SERIAL_ADDER_OVF_EN: a = 0111, b = 0001, cin = 0 -> sum = 1000, cout = 0, ovf = 1. a = 1000, b = 1111 -> sum = 0111, cout = 1, ovf = 1. a = 0011, b = 0001 -> ovf = 0.
